rastreador_extremos: RTL and testbench

- Downstream consumer of the team's 4-bit magnitude comparator (igual/maior/menor outputs).
- Accepts a stream of unsigned samples and tracks the running maximum and minimum over fixed windows of JANELA samples.
- At the end of each window, publishes the window's max/min and pulses a done flag, then restarts.
- Feeds display/decision logic that needs per-window extremes.

---
 rtl/rastreador_extremos_pkg.sv | 17 +
 rtl/rastreador_extremos_comparador.sv | 23 ++
 rtl/rastreador_extremos.sv | 133 +++++++++++++
 tb/tb_rastreador_extremos.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/rastreador_extremos_pkg.sv
// Shared definitions for the per-window extremes tracker: default sample width,
// state encoding and the width helper for the sample counter.
package rastreador_extremos_pkg;

   localparam int unsigned LARGURA_PADRAO = 4;

   typedef enum logic {
      VAZIO      = 1'b0,
      ACUMULANDO = 1'b1
   } estado_t;

   // Counter must be able to hold 0..janela.
   function automatic int unsigned largura_contagem(input int unsigned janela);
      return $clog2(janela + 1);
   endfunction

endpackage : rastreador_extremos_pkg

// File: rtl/rastreador_extremos_comparador.sv
// Unsigned magnitude comparator (a versus b), purely combinational.
// Ports:
//   a, b     : operands, LARGURA bits, unsigned
//   igual_c  : a == b
//   maior_c  : a >  b
//   menor_c  : a <  b
module rastreador_extremos_comparador
   import rastreador_extremos_pkg::*;
#(
   parameter int unsigned LARGURA = LARGURA_PADRAO
) (
   input  logic [LARGURA-1:0] a,
   input  logic [LARGURA-1:0] b,
   output logic               igual_c,
   output logic               maior_c,
   output logic               menor_c
);

   assign igual_c = (a == b);
   assign maior_c = (a > b);
   assign menor_c = (a < b);

endmodule : rastreador_extremos_comparador

// File: rtl/rastreador_extremos.sv
// Tracks running max/min of an unsigned sample stream over windows of JANELA
// accepted samples; publishes the window extremes and pulses janela_pronta when
// the last sample of a window is accepted, then starts a new window.
// Ports:
//   clk            : clock, rising edge
//   rst            : synchronous active-high reset
//   amostra_valida : sample qualifier, sample accepted on every edge it is 1
//   amostra        : sample value
//   maximo         : max of last completed window (registered)
//   minimo         : min of last completed window (registered)
//   janela_pronta  : one-cycle pulse when maximo/minimo have just updated
//   contagem       : samples accepted in the current window
module rastreador_extremos
   import rastreador_extremos_pkg::*;
#(
   parameter int unsigned LARGURA = LARGURA_PADRAO,
   parameter int unsigned JANELA  = 8
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  amostra_valida,
   input  logic [LARGURA-1:0]                    amostra,
   output logic [LARGURA-1:0]                    maximo,
   output logic [LARGURA-1:0]                    minimo,
   output logic                                  janela_pronta,
   output logic [largura_contagem(JANELA)-1:0]   contagem
);

   localparam int unsigned CW = largura_contagem(JANELA);

   estado_t            estado, estado_nxt;
   logic [LARGURA-1:0] max_acc, max_acc_nxt;
   logic [LARGURA-1:0] min_acc, min_acc_nxt;
   logic [LARGURA-1:0] maximo_nxt, minimo_nxt;
   logic [CW-1:0]      contagem_nxt;
   logic               janela_pronta_nxt;

   logic [LARGURA-1:0] max_cand, min_cand;
   logic               maior_max, menor_max, igual_max;
   logic               maior_min, menor_min, igual_min;

   // One compare against each accumulator.
   rastreador_extremos_comparador #(.LARGURA(LARGURA)) u_cmp_max (
      .a       (amostra),
      .b       (max_acc),
      .igual_c (igual_max),
      .maior_c (maior_max),
      .menor_c (menor_max)
   );

   rastreador_extremos_comparador #(.LARGURA(LARGURA)) u_cmp_min (
      .a       (amostra),
      .b       (min_acc),
      .igual_c (igual_min),
      .maior_c (maior_min),
      .menor_c (menor_min)
   );

   // Comparator outputs not needed for the extremes update.
   logic sinais_unused;
   assign sinais_unused = &{1'b0, igual_max, menor_max, igual_min, maior_min};

   // Ties keep the accumulator unchanged.
   assign max_cand = maior_max ? amostra : max_acc;
   assign min_cand = menor_min ? amostra : min_acc;

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         estado        <= VAZIO;
         max_acc       <= '0;
         min_acc       <= '0;
         maximo        <= '0;
         minimo        <= '0;
         contagem      <= '0;
         janela_pronta <= 1'b0;
      end else begin
         estado        <= estado_nxt;
         max_acc       <= max_acc_nxt;
         min_acc       <= min_acc_nxt;
         maximo        <= maximo_nxt;
         minimo        <= minimo_nxt;
         contagem      <= contagem_nxt;
         janela_pronta <= janela_pronta_nxt;
      end
   end

   // Next-state, accumulator and publish logic.
   always_comb begin
      estado_nxt        = estado;
      max_acc_nxt       = max_acc;
      min_acc_nxt       = min_acc;
      maximo_nxt        = maximo;
      minimo_nxt        = minimo;
      contagem_nxt      = contagem;
      janela_pronta_nxt = 1'b0;

      if (amostra_valida) begin
         unique case (estado)
            VAZIO: begin
               max_acc_nxt = amostra;
               min_acc_nxt = amostra;
               if (JANELA == 1) begin
                  // Single-sample windows publish on every accepted sample.
                  maximo_nxt        = amostra;
                  minimo_nxt        = amostra;
                  janela_pronta_nxt = 1'b1;
                  contagem_nxt      = '0;
                  estado_nxt        = VAZIO;
               end else begin
                  contagem_nxt = CW'(1);
                  estado_nxt   = ACUMULANDO;
               end
            end
            ACUMULANDO: begin
               max_acc_nxt = max_cand;
               min_acc_nxt = min_cand;
               if (contagem == CW'(JANELA - 1)) begin
                  maximo_nxt        = max_cand;
                  minimo_nxt        = min_cand;
                  janela_pronta_nxt = 1'b1;
                  contagem_nxt      = '0;
                  estado_nxt        = VAZIO;
               end else begin
                  contagem_nxt = contagem + CW'(1);
               end
            end
            default: estado_nxt = VAZIO;
         endcase
      end
   end

endmodule : rastreador_extremos

// File: tb/tb_rastreador_extremos.sv
// Directed bench for rastreador_extremos: one instance with JANELA=8 and one
// with JANELA=1, expected values computed by hand.
module tb_rastreador_extremos;

   logic       clk;
   logic       rst, valida;
   logic [3:0] amostra;
   logic [3:0] maximo, minimo;
   logic       pronta;
   logic [3:0] contagem;

   logic       rst1, valida1;
   logic [3:0] amostra1;
   logic [3:0] maximo1, minimo1;
   logic       pronta1;
   logic [0:0] contagem1;

   int checks = 0;
   int erros  = 0;

   rastreador_extremos #(.LARGURA(4), .JANELA(8)) dut8 (
      .clk            (clk),
      .rst            (rst),
      .amostra_valida (valida),
      .amostra        (amostra),
      .maximo         (maximo),
      .minimo         (minimo),
      .janela_pronta  (pronta),
      .contagem       (contagem)
   );

   rastreador_extremos #(.LARGURA(4), .JANELA(1)) dut1 (
      .clk            (clk),
      .rst            (rst1),
      .amostra_valida (valida1),
      .amostra        (amostra1),
      .maximo         (maximo1),
      .minimo         (minimo1),
      .janela_pronta  (pronta1),
      .contagem       (contagem1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic verifica(input string tag, input logic [7:0] obs, input logic [7:0] esp);
      checks++;
      assert (obs === esp) else begin
         erros++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, esp);
      end
   endtask

   // One clock on the JANELA=8 instance; inputs change on the falling edge.
   task automatic passo(input logic r, input logic v, input logic [3:0] a);
      @(negedge clk);
      rst = r; valida = v; amostra = a;
      @(posedge clk);
      #1;
   endtask

   task automatic passo1(input logic r, input logic v, input logic [3:0] a);
      @(negedge clk);
      rst1 = r; valida1 = v; amostra1 = a;
      @(posedge clk);
      #1;
   endtask

   logic [3:0] seq_a [8];
   logic [3:0] seq_b [8];
   logic [3:0] seq_d [3];

   initial begin
      seq_a = '{4'd3, 4'd9, 4'd1, 4'd7, 4'd7, 4'd15, 4'd0, 4'd4};
      seq_b = '{4'd0, 4'd15, 4'd15, 4'd0, 4'd8, 4'd8, 4'd8, 4'd8};
      seq_d = '{4'd4, 4'd12, 4'd1};
      rst = 1'b1; valida = 1'b0; amostra = '0;
      rst1 = 1'b1; valida1 = 1'b0; amostra1 = '0;

      // Reset state
      passo(1'b1, 1'b0, 4'd0);
      passo(1'b0, 1'b0, 4'd0);
      verifica("reset_maximo", 8'(maximo), 8'd0);
      verifica("reset_minimo", 8'(minimo), 8'd0);
      verifica("reset_pronta", 8'(pronta), 8'd0);
      verifica("reset_contagem", 8'(contagem), 8'd0);

      // Window with valid every cycle
      for (int i = 0; i < 8; i++) begin
         passo(1'b0, 1'b1, seq_a[i]);
         if (i < 7) begin
            verifica("t1_contagem", 8'(contagem), 8'(i + 1));
            verifica("t1_pronta_low", 8'(pronta), 8'd0);
            verifica("t1_maximo_hold", 8'(maximo), 8'd0);
         end
      end
      verifica("t1_maximo", 8'(maximo), 8'd15);
      verifica("t1_minimo", 8'(minimo), 8'd0);
      verifica("t1_pronta", 8'(pronta), 8'd1);
      verifica("t1_contagem_wrap", 8'(contagem), 8'd0);
      passo(1'b0, 1'b0, 4'd0);
      verifica("t1_pronta_drop", 8'(pronta), 8'd0);
      verifica("t1_maximo_keep", 8'(maximo), 8'd15);

      // Same samples with two-cycle gaps, after a clearing reset
      passo(1'b1, 1'b0, 4'd0);
      verifica("t2_reset_maximo", 8'(maximo), 8'd0);
      for (int i = 0; i < 8; i++) begin
         passo(1'b0, 1'b1, seq_a[i]);
         if (i < 7) begin
            for (int g = 0; g < 2; g++) begin
               passo(1'b0, 1'b0, 4'd15);
               verifica("t2_contagem_gap", 8'(contagem), 8'(i + 1));
               verifica("t2_pronta_gap", 8'(pronta), 8'd0);
            end
         end
      end
      verifica("t2_maximo", 8'(maximo), 8'd15);
      verifica("t2_minimo", 8'(minimo), 8'd0);
      verifica("t2_pronta", 8'(pronta), 8'd1);
      passo(1'b0, 1'b0, 4'd0);
      verifica("t2_pronta_drop", 8'(pronta), 8'd0);

      // All-equal window followed back-to-back by a tie-heavy window
      for (int i = 0; i < 8; i++) passo(1'b0, 1'b1, 4'd5);
      verifica("t3_maximo_a", 8'(maximo), 8'd5);
      verifica("t3_minimo_a", 8'(minimo), 8'd5);
      verifica("t3_pronta_a", 8'(pronta), 8'd1);
      for (int i = 0; i < 8; i++) begin
         passo(1'b0, 1'b1, seq_b[i]);
         if (i == 0) begin
            verifica("t3_b2b_contagem", 8'(contagem), 8'd1);
            verifica("t3_b2b_pronta", 8'(pronta), 8'd0);
            verifica("t3_b2b_maximo", 8'(maximo), 8'd5);
         end
      end
      verifica("t3_maximo_b", 8'(maximo), 8'd15);
      verifica("t3_minimo_b", 8'(minimo), 8'd0);
      verifica("t3_pronta_b", 8'(pronta), 8'd1);

      // Reset mid-window discards the partial window
      passo(1'b0, 1'b1, 4'd2);
      passo(1'b0, 1'b1, 4'd14);
      passo(1'b0, 1'b1, 4'd6);
      verifica("t4_contagem_pre", 8'(contagem), 8'd3);
      passo(1'b1, 1'b0, 4'd0);
      verifica("t4_reset_maximo", 8'(maximo), 8'd0);
      verifica("t4_reset_minimo", 8'(minimo), 8'd0);
      verifica("t4_reset_contagem", 8'(contagem), 8'd0);
      for (int i = 0; i < 8; i++) passo(1'b0, 1'b1, 4'd10);
      verifica("t4_maximo", 8'(maximo), 8'd10);
      verifica("t4_minimo", 8'(minimo), 8'd10);
      verifica("t4_pronta", 8'(pronta), 8'd1);

      // Reset and valid in the same cycle: reset wins
      passo(1'b0, 1'b1, 4'd3);
      passo(1'b1, 1'b1, 4'd11);
      verifica("t6_contagem", 8'(contagem), 8'd0);
      verifica("t6_maximo", 8'(maximo), 8'd0);
      verifica("t6_minimo", 8'(minimo), 8'd0);
      verifica("t6_pronta", 8'(pronta), 8'd0);
      passo(1'b0, 1'b0, 4'd0);
      verifica("t6_contagem_after", 8'(contagem), 8'd0);

      // JANELA=1: every accepted sample publishes
      passo1(1'b1, 1'b0, 4'd0);
      passo1(1'b0, 1'b0, 4'd0);
      verifica("t5_reset_pronta", 8'(pronta1), 8'd0);
      for (int i = 0; i < 3; i++) begin
         passo1(1'b0, 1'b1, seq_d[i]);
         verifica("t5_pronta", 8'(pronta1), 8'd1);
         verifica("t5_maximo", 8'(maximo1), 8'(seq_d[i]));
         verifica("t5_minimo", 8'(minimo1), 8'(seq_d[i]));
         verifica("t5_contagem", 8'(contagem1), 8'd0);
      end
      passo1(1'b0, 1'b0, 4'd0);
      verifica("t5_pronta_drop", 8'(pronta1), 8'd0);
      verifica("t5_maximo_keep", 8'(maximo1), 8'd1);

      $display("CHECKS %0d ERRORS %0d", checks, erros);
      $finish;
   end

endmodule : tb_rastreador_extremos
